mclr5_issue_commit: RTL and testbench

MCLR5_ISSUE_COMMIT -- requirements
Module: mclr5_issue_commit

---
 rtl/mclr5_pkg.sv | 18 +
 rtl/mclr5_fwd_mux.sv | 31 +++
 rtl/mclr5_issue_commit.sv | 195 +++++++++++++++++++
 tb/tb_mclr5_issue_commit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mclr5_pkg.sv
// Shared types and constants for the mclr5 issue/commit block.
package mclr5_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_WAIT,
      ST_REDIRECT
   } state_t;

   // Register 0 is hardwired to zero; indices past the implemented file do not exist.
   function automatic logic reg_ok(input logic [REG_IDX_W-1:0] idx, input int unsigned nregs);
      return (idx != '0) && (32'(idx) < nregs);
   endfunction

endpackage

// File: rtl/mclr5_fwd_mux.sv
// Operand bypass for one source of one slot: nearest earlier slot result, else register file.
module mclr5_fwd_mux
   import mclr5_pkg::*;
#(
   parameter int unsigned ISSUE_W  = 4,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned SLOT     = 0
)(
   input  logic [REG_IDX_W-1:0]         rs_idx,
   input  logic [ISSUE_W-1:0]           rd_valid,
   input  logic [REG_IDX_W*ISSUE_W-1:0] rd_idx,
   input  logic [XLEN*ISSUE_W-1:0]      rd_data,
   input  logic [XLEN-1:0]              rf_data,
   output logic [XLEN-1:0]              data
);

   always_comb begin
      data = rf_data;
      // Ascending scan so the closest preceding producer overrides older ones.
      for (int unsigned j = 0; j < ISSUE_W; j++) begin
         if ((j < SLOT) && rd_valid[j] &&
             (rd_idx[j*REG_IDX_W +: REG_IDX_W] == rs_idx)) begin
            data = rd_data[j*XLEN +: XLEN];
         end
      end
      if (!reg_ok(rs_idx, NUM_REGS)) begin
         data = '0;
      end
   end

endmodule

// File: rtl/mclr5_issue_commit.sv
// Bundle issue/commit with operand bypass, branch redirect and a single blocking memory port.
// Optional retired-slot counter enabled by defining MCLR5_ISSUE_COMMIT_PERF_EN.
module mclr5_issue_commit
   import mclr5_pkg::*;
#(
   parameter int unsigned ISSUE_W  = 4,
   parameter int unsigned NUM_REGS = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic                         CORE_CLK,
   input  logic                         RST_n,
   input  logic                         BUNDLE_VALID,
   input  logic [REG_IDX_W*ISSUE_W-1:0] SLOT_RS1_IDX,
   input  logic [REG_IDX_W*ISSUE_W-1:0] SLOT_RS2_IDX,
   output logic [XLEN*ISSUE_W-1:0]      SLOT_RS1_DATA,
   output logic [XLEN*ISSUE_W-1:0]      SLOT_RS2_DATA,
   input  logic [ISSUE_W-1:0]           SLOT_RD_VALID,
   input  logic [REG_IDX_W*ISSUE_W-1:0] SLOT_RD_IDX,
   input  logic [XLEN*ISSUE_W-1:0]      SLOT_RD_DATA,
   input  logic [ISSUE_W-1:0]           SLOT_BR_TAKEN,
   input  logic [XLEN*ISSUE_W-1:0]      SLOT_BR_TARGET,
   input  logic [ISSUE_W-1:0]           SLOT_MEM_REQ,
   input  logic [ISSUE_W-1:0]           SLOT_MEM_WE,
   input  logic [XLEN-1:0]              MEM0_ADDR,
   input  logic [XLEN-1:0]              MEM0_WDATA,
   output logic [XLEN-1:0]              PC,
`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
   output logic [XLEN-1:0]              RETIRED_CNT,
`endif
   output logic                         MEM_REQ,
   output logic                         MEM_WE,
   output logic [XLEN-1:0]              MEM_ADDR,
   output logic [XLEN-1:0]              MEM_WDATA,
   input  logic [XLEN-1:0]              MEM_RDATA,
   input  logic                         MEM_ACK
);

   localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_t                 state, state_nxt;
   logic [XLEN-1:0]        pc;
   logic [XLEN-1:0]        regs [NUM_REGS];
   logic                   cap_we;
   logic [REG_IDX_W-1:0]   cap_rd;
   logic [XLEN-1:0]        cap_addr, cap_wdata;
   logic [REG_IDX_W-1:0]   rd_idx [ISSUE_W];
   logic                   mem0, br_hit, stop, fire, ack;
   logic [XLEN-1:0]        k_cnt, br_target;
   logic [ISSUE_W-1:0]     commit;

   for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
      logic [REG_IDX_W-1:0] rs1, rs2;
      assign rs1       = SLOT_RS1_IDX[g*REG_IDX_W +: REG_IDX_W];
      assign rs2       = SLOT_RS2_IDX[g*REG_IDX_W +: REG_IDX_W];
      assign rd_idx[g] = SLOT_RD_IDX[g*REG_IDX_W +: REG_IDX_W];

      mclr5_fwd_mux #(.ISSUE_W(ISSUE_W), .NUM_REGS(NUM_REGS), .SLOT(g)) u_rs1 (
         .rs_idx   (rs1),
         .rd_valid (SLOT_RD_VALID),
         .rd_idx   (SLOT_RD_IDX),
         .rd_data  (SLOT_RD_DATA),
         .rf_data  (regs[rs1[RW-1:0]]),
         .data     (SLOT_RS1_DATA[g*XLEN +: XLEN])
      );

      mclr5_fwd_mux #(.ISSUE_W(ISSUE_W), .NUM_REGS(NUM_REGS), .SLOT(g)) u_rs2 (
         .rs_idx   (rs2),
         .rd_valid (SLOT_RD_VALID),
         .rd_idx   (SLOT_RD_IDX),
         .rd_data  (SLOT_RD_DATA),
         .rf_data  (regs[rs2[RW-1:0]]),
         .data     (SLOT_RS2_DATA[g*XLEN +: XLEN])
      );
   end

   // Memory takes precedence over a branch in the same slot; slot 0 memory gives k=0.
   always_comb begin
      mem0      = SLOT_MEM_REQ[0];
      br_hit    = 1'b0;
      br_target = '0;
      k_cnt     = ISSUE_W;
      stop      = 1'b0;
      commit    = '0;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         if (!stop) begin
            if (SLOT_MEM_REQ[i]) begin
               k_cnt = i;
               stop  = 1'b1;
            end else if (SLOT_BR_TAKEN[i]) begin
               k_cnt     = i + 1;
               br_hit    = 1'b1;
               br_target = SLOT_BR_TARGET[i*XLEN +: XLEN];
               stop      = 1'b1;
            end
         end
      end
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         commit[i] = (i < k_cnt);
      end
   end

   assign fire = (state == ST_IDLE) && BUNDLE_VALID;
   assign ack  = (state == ST_MEM_WAIT) && MEM_ACK;

   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (fire) begin
               if (mem0)        state_nxt = ST_MEM_WAIT;
               else if (br_hit) state_nxt = ST_REDIRECT;
            end
         end
         ST_MEM_WAIT: if (MEM_ACK) state_nxt = ST_IDLE;
         ST_REDIRECT: state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      MEM_REQ   = (state == ST_MEM_WAIT);
      MEM_WE    = cap_we;
      MEM_ADDR  = cap_addr;
      MEM_WDATA = cap_wdata;
      PC        = pc;
   end

   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         pc        <= RESET_PC;
         cap_we    <= 1'b0;
         cap_rd    <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (fire) begin
         if (mem0) begin
            cap_we    <= SLOT_MEM_WE[0];
            cap_rd    <= rd_idx[0];
            cap_addr  <= MEM0_ADDR;
            cap_wdata <= MEM0_WDATA;
         end else if (br_hit) begin
            pc <= br_target;
         end else begin
            pc <= pc + (k_cnt << 2);
         end
      end else if (ack) begin
         pc <= pc + 32'd4;
      end
   end

   // Later committed slots are assigned last, so they win on a shared rd.
   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         if (fire) begin
            for (int unsigned i = 0; i < ISSUE_W; i++) begin
               if (commit[i] && SLOT_RD_VALID[i] && reg_ok(rd_idx[i], NUM_REGS)) begin
                  regs[rd_idx[i][RW-1:0]] <= SLOT_RD_DATA[i*XLEN +: XLEN];
               end
            end
         end
         if (ack && !cap_we && reg_ok(cap_rd, NUM_REGS)) begin
            regs[cap_rd[RW-1:0]] <= MEM_RDATA;
         end
      end
   end

`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
   logic [XLEN-1:0] retired;

   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         retired <= '0;
      end else if (fire) begin
         retired <= retired + k_cnt;
      end else if (ack) begin
         retired <= retired + 32'd1;
      end
   end

   assign RETIRED_CNT = retired;
`endif

endmodule

// File: tb/tb_mclr5_issue_commit.sv
// Scoreboard bench for mclr5_issue_commit; expectations are queued with stimulus and drained against the DUT.
module tb_mclr5_issue_commit;

   localparam int unsigned W = 4;

   logic              CORE_CLK = 1'b0;
   logic              RST_n;
   logic              BUNDLE_VALID;
   logic [5*W-1:0]    SLOT_RS1_IDX, SLOT_RS2_IDX, SLOT_RD_IDX;
   logic [32*W-1:0]   SLOT_RS1_DATA, SLOT_RS2_DATA, SLOT_RD_DATA, SLOT_BR_TARGET;
   logic [W-1:0]      SLOT_RD_VALID, SLOT_BR_TAKEN, SLOT_MEM_REQ, SLOT_MEM_WE;
   logic [31:0]       MEM0_ADDR, MEM0_WDATA, PC, MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic              MEM_REQ, MEM_WE, MEM_ACK;
`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
   logic [31:0]       RETIRED_CNT;
`endif

   mclr5_issue_commit #(.ISSUE_W(W), .NUM_REGS(8), .RESET_PC(32'h0000_0000)) dut (
      .CORE_CLK       (CORE_CLK),
      .RST_n          (RST_n),
      .BUNDLE_VALID   (BUNDLE_VALID),
      .SLOT_RS1_IDX   (SLOT_RS1_IDX),
      .SLOT_RS2_IDX   (SLOT_RS2_IDX),
      .SLOT_RS1_DATA  (SLOT_RS1_DATA),
      .SLOT_RS2_DATA  (SLOT_RS2_DATA),
      .SLOT_RD_VALID  (SLOT_RD_VALID),
      .SLOT_RD_IDX    (SLOT_RD_IDX),
      .SLOT_RD_DATA   (SLOT_RD_DATA),
      .SLOT_BR_TAKEN  (SLOT_BR_TAKEN),
      .SLOT_BR_TARGET (SLOT_BR_TARGET),
      .SLOT_MEM_REQ   (SLOT_MEM_REQ),
      .SLOT_MEM_WE    (SLOT_MEM_WE),
      .MEM0_ADDR      (MEM0_ADDR),
      .MEM0_WDATA     (MEM0_WDATA),
      .PC             (PC),
`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
      .RETIRED_CNT    (RETIRED_CNT),
`endif
      .MEM_REQ        (MEM_REQ),
      .MEM_WE         (MEM_WE),
      .MEM_ADDR       (MEM_ADDR),
      .MEM_WDATA      (MEM_WDATA),
      .MEM_RDATA      (MEM_RDATA),
      .MEM_ACK        (MEM_ACK)
   );

   always #50 CORE_CLK = ~CORE_CLK;

   typedef enum {K_PC, K_REG, K_FWD1, K_MEM_REQ, K_MEM_ADDR, K_MEM_WE, K_MEM_WDATA, K_RETIRED} kind_t;
   typedef struct {
      string       tag;
      kind_t       kind;
      int unsigned idx;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic push(input string tag, input kind_t kind, input int unsigned idx, input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Register reads go through slot 0 RS1, which has no earlier producer to bypass from.
   task automatic drain();
      exp_t        e;
      logic [31:0] got;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_PC:        got = PC;
            K_REG: begin
               BUNDLE_VALID      = 1'b0;
               SLOT_RS1_IDX[4:0] = e.idx[4:0];
               #1;
               got = SLOT_RS1_DATA[31:0];
            end
            K_FWD1:      got = SLOT_RS1_DATA[e.idx*32 +: 32];
            K_MEM_REQ:   got = {31'b0, MEM_REQ};
            K_MEM_ADDR:  got = MEM_ADDR;
            K_MEM_WE:    got = {31'b0, MEM_WE};
            K_MEM_WDATA: got = MEM_WDATA;
`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
            K_RETIRED:   got = RETIRED_CNT;
`endif
            default:     got = 'x;
         endcase
         check(e.tag, got, e.val);
      end
   endtask

   task automatic step();
      @(posedge CORE_CLK);
      #1;
   endtask

   task automatic clear_bundle();
      BUNDLE_VALID   = 1'b0;
      SLOT_RS1_IDX   = '0;
      SLOT_RS2_IDX   = '0;
      SLOT_RD_IDX    = '0;
      SLOT_RD_DATA   = '0;
      SLOT_RD_VALID  = '0;
      SLOT_BR_TAKEN  = '0;
      SLOT_BR_TARGET = '0;
      SLOT_MEM_REQ   = '0;
      SLOT_MEM_WE    = '0;
      MEM0_ADDR      = '0;
      MEM0_WDATA     = '0;
   endtask

   task automatic set_rd(input int unsigned i, input logic [4:0] idx, input logic [31:0] data);
      SLOT_RD_VALID[i]       = 1'b1;
      SLOT_RD_IDX[i*5 +: 5]  = idx;
      SLOT_RD_DATA[i*32 +: 32] = data;
   endtask

   task automatic set_rs1(input int unsigned i, input logic [4:0] idx);
      SLOT_RS1_IDX[i*5 +: 5] = idx;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_n     = 1'b0;
      MEM_ACK   = 1'b0;
      MEM_RDATA = '0;
      clear_bundle();
      repeat (2) step();
      RST_n = 1'b1;

      push("rst_pc", K_PC, 0, 32'h0);
      push("rst_mem_req", K_MEM_REQ, 0, 32'h0);
      push("rst_mem_addr", K_MEM_ADDR, 0, 32'h0);
      push("rst_mem_we", K_MEM_WE, 0, 32'h0);
      push("rst_reg1", K_REG, 1, 32'h0);
      drain();

      // Four independent results, full commit.
      clear_bundle();
      for (int unsigned i = 0; i < W; i++) set_rd(i, 5'(i + 1), 32'(11 * (i + 1)));
      BUNDLE_VALID = 1'b1;
      step();
      clear_bundle();
      push("full_pc", K_PC, 0, 32'd16);
      for (int unsigned i = 0; i < W; i++) push("full_reg", K_REG, i + 1, 32'(11 * (i + 1)));
      drain();

      // Intra-bundle bypass, same-rd priority, out-of-range rd ignored.
      clear_bundle();
      set_rd(0, 5'd1, 32'd5);
      set_rd(1, 5'd1, 32'd7);
      set_rd(2, 5'd9, 32'h99);
      set_rd(3, 5'd0, 32'hFF);
      set_rs1(0, 5'd1);
      set_rs1(1, 5'd1);
      set_rs1(2, 5'd1);
      set_rs1(3, 5'd1);
      BUNDLE_VALID = 1'b1;
      push("fwd_slot0_rf", K_FWD1, 0, 32'd11);
      push("fwd_slot1", K_FWD1, 1, 32'd5);
      push("fwd_slot2_nearest", K_FWD1, 2, 32'd7);
      push("fwd_slot3_skip_rd9", K_FWD1, 3, 32'd7);
      drain();
      step();
      clear_bundle();
      push("waw_pc", K_PC, 0, 32'd32);
      push("waw_reg1", K_REG, 1, 32'd7);
      drain();

      // Taken branch in slot 2; slot 3 dropped; one redirect bubble.
      clear_bundle();
      set_rd(0, 5'd2, 32'h200);
      set_rd(1, 5'd3, 32'h300);
      set_rd(2, 5'd5, 32'h555);
      set_rd(3, 5'd4, 32'h999);
      SLOT_BR_TAKEN[2]        = 1'b1;
      SLOT_BR_TARGET[64 +: 32] = 32'h100;
      BUNDLE_VALID = 1'b1;
      step();
      push("br_pc", K_PC, 0, 32'h100);
      drain();
      clear_bundle();
      set_rd(0, 5'd6, 32'h66);
      BUNDLE_VALID = 1'b1;
      step();
      push("redirect_no_commit_pc", K_PC, 0, 32'h100);
      drain();
      step();
      clear_bundle();
      push("after_redirect_pc", K_PC, 0, 32'h110);
      push("br_reg2", K_REG, 2, 32'h200);
      push("br_reg3", K_REG, 3, 32'h300);
      push("br_reg5", K_REG, 5, 32'h555);
      push("br_dropped_reg4", K_REG, 4, 32'd44);
      push("after_redirect_reg6", K_REG, 6, 32'h66);
      drain();

      // Memory op in slot 2 truncates the bundle to two slots.
      clear_bundle();
      set_rd(0, 5'd1, 32'h1);
      set_rd(1, 5'd7, 32'h77);
      set_rd(2, 5'd2, 32'hBAD);
      set_rd(3, 5'd3, 32'hBAD);
      SLOT_MEM_REQ[2] = 1'b1;
      BUNDLE_VALID = 1'b1;
      step();
      clear_bundle();
      push("trunc_pc", K_PC, 0, 32'h118);
      push("trunc_reg1", K_REG, 1, 32'h1);
      push("trunc_reg7", K_REG, 7, 32'h77);
      push("trunc_reg2", K_REG, 2, 32'h200);
      push("trunc_reg3", K_REG, 3, 32'h300);
      drain();

      // Slot-0 load held three cycles before ACK.
      clear_bundle();
      SLOT_MEM_REQ[0] = 1'b1;
      MEM0_ADDR       = 32'h40;
      MEM0_WDATA      = 32'h5555;
      set_rd(0, 5'd4, 32'h1234);
      set_rd(1, 5'd5, 32'hEEE);
      BUNDLE_VALID = 1'b1;
      step();
      clear_bundle();
      MEM0_ADDR = 32'h999;
      push("ld_req_c1", K_MEM_REQ, 0, 32'h1);
      push("ld_addr_c1", K_MEM_ADDR, 0, 32'h40);
      push("ld_we", K_MEM_WE, 0, 32'h0);
      push("ld_wait_pc", K_PC, 0, 32'h118);
      drain();
      step();
      push("ld_req_c2", K_MEM_REQ, 0, 32'h1);
      push("ld_addr_c2", K_MEM_ADDR, 0, 32'h40);
      drain();
      step();
      push("ld_req_c3", K_MEM_REQ, 0, 32'h1);
      drain();
      MEM_ACK   = 1'b1;
      MEM_RDATA = 32'hDEAD;
      step();
      MEM_ACK = 1'b0;
      push("ld_done_req", K_MEM_REQ, 0, 32'h0);
      push("ld_done_pc", K_PC, 0, 32'h11C);
      push("ld_reg4", K_REG, 4, 32'hDEAD);
      push("ld_reg5_untouched", K_REG, 5, 32'h555);
      drain();

      // ACK while idle must be ignored.
      MEM_ACK   = 1'b1;
      MEM_RDATA = 32'hBEEF;
      step();
      MEM_ACK = 1'b0;
      push("stray_ack_pc", K_PC, 0, 32'h11C);
      push("stray_ack_reg4", K_REG, 4, 32'hDEAD);
      push("stray_ack_req", K_MEM_REQ, 0, 32'h0);
      drain();

      // Store pending when reset hits.
      clear_bundle();
      SLOT_MEM_REQ[0] = 1'b1;
      SLOT_MEM_WE[0]  = 1'b1;
      MEM0_ADDR       = 32'h80;
      MEM0_WDATA      = 32'hCAFE;
      BUNDLE_VALID = 1'b1;
      step();
      clear_bundle();
      push("st_req", K_MEM_REQ, 0, 32'h1);
      push("st_we", K_MEM_WE, 0, 32'h1);
      push("st_wdata", K_MEM_WDATA, 0, 32'hCAFE);
      drain();
      #10;
      RST_n = 1'b0;
      push("rstw_req", K_MEM_REQ, 0, 32'h0);
      push("rstw_pc", K_PC, 0, 32'h0);
      push("rstw_we", K_MEM_WE, 0, 32'h0);
      push("rstw_addr", K_MEM_ADDR, 0, 32'h0);
      push("rstw_wdata", K_MEM_WDATA, 0, 32'h0);
      push("rstw_reg4", K_REG, 4, 32'h0);
      drain();
      step();
      RST_n   = 1'b1;
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      push("post_rst_ack_req", K_MEM_REQ, 0, 32'h0);
      push("post_rst_ack_pc", K_PC, 0, 32'h0);
      push("post_rst_ack_reg4", K_REG, 4, 32'h0);
      drain();

`ifdef MCLR5_ISSUE_COMMIT_PERF_EN
      push("perf_rst", K_RETIRED, 0, 32'h0);
      drain();
      clear_bundle();
      BUNDLE_VALID = 1'b1;
      step();
      step();
      clear_bundle();
      SLOT_MEM_REQ[0] = 1'b1;
      SLOT_MEM_WE[0]  = 1'b1;
      BUNDLE_VALID = 1'b1;
      step();
      clear_bundle();
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      push("perf_retired", K_RETIRED, 0, 32'd9);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
